// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file write-back arbiter.
package regfile_wb_arbiter_pkg;

  localparam int unsigned DATA_W_DFLT = 32;
  localparam int unsigned ADDR_W_DFLT = 5;
  localparam int unsigned CNT_W_DFLT  = 16;

  // Writes to this register are accepted but never reach the register file.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Requester index; also the encoding of the round-robin "last winner".
  typedef enum logic {
    Req0 = 1'b0,
    Req1 = 1'b1
  } reqIdx_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Two-way round-robin grant with its own last-winner register.
module rr_arbiter2
  import regfile_wb_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic valid0,
  input  logic valid1,
  input  logic update,   // a transfer happens this cycle
  input  logic clear,    // return priority to the reset state
  output logic grant0,
  output logic grant1
);

  reqIdx_t rrLastQ, rrLastD;

  // Grant the lone requester, or the one that did not win last on a conflict.
  always_comb begin
    grant0 = valid0 && (!valid1 || (rrLastQ == Req1));
    grant1 = valid1 && (!valid0 || (rrLastQ == Req0));
  end

  // Next last-winner: clear has priority, then the accepted requester.
  always_comb begin
    rrLastD = rrLastQ;
    if (clear) begin
      rrLastD = Req1;
    end else if (update) begin
      rrLastD = grant1 ? Req1 : Req0;
    end
  end

  // Last-winner register; reset to Req1 so requester 0 wins the first conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      rrLastQ <= Req1;
    end else begin
      rrLastQ <= rrLastD;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between the ALU and load paths.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DFLT,
  parameter int unsigned ADDR_W = ADDR_W_DFLT,
  parameter int unsigned CNT_W  = CNT_W_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              hold,
  input  logic              flush,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  output logic [CNT_W-1:0]  conflict_cnt
);

  logic              grant0, grant1;
  logic              xfer0, xfer1, xferAny;
  logic [ADDR_W-1:0] winAddr;
  logic [DATA_W-1:0] winData;

  logic              regWriteQ;
  logic [ADDR_W-1:0] writeRegQ;
  logic [DATA_W-1:0] writeDataQ;
  logic [CNT_W-1:0]  cntQ;

  rr_arbiter2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .update (xferAny),
    .clear  (flush),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  // Ready gating and winner selection; flush and reset block all acceptance.
  always_comb begin
    req0_ready = grant0 && !hold && !flush && !rst;
    req1_ready = grant1 && !hold && !flush && !rst;
    xfer0      = req0_valid && req0_ready;
    xfer1      = req1_valid && req1_ready;
    xferAny    = xfer0 || xfer1;
    winAddr    = xfer1 ? req1_addr : req0_addr;
    winData    = xfer1 ? req1_data : req0_data;
  end

  // Output stage: one registered write per accepted transfer, $0 suppressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      regWriteQ  <= 1'b0;
      writeRegQ  <= '0;
      writeDataQ <= '0;
    end else if (flush) begin
      regWriteQ  <= 1'b0;
    end else if (xferAny) begin
      regWriteQ  <= (winAddr != ADDR_W'(REG_ZERO));
      writeRegQ  <= winAddr;
      writeDataQ <= winData;
    end else begin
      regWriteQ  <= 1'b0;
    end
  end

  // Saturating count of accepted transfers made while both requesters waited.
  always_ff @(posedge clk) begin
    if (rst) begin
      cntQ <= '0;
    end else if (req0_valid && req1_valid && xferAny && (cntQ != '1)) begin
      cntQ <= cntQ + CNT_W'(1);
    end
  end

  assign RegWrite      = regWriteQ;
  assign WriteRegister = writeRegQ;
  assign WriteData     = writeDataQ;
  assign conflict_cnt  = cntQ;

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 32x32 register file between two write-back requesters: req0 is the ALU result path and req1 is the load/multi-cycle unit.
- Arbitrates round-robin using a valid/ready handshake.
- Registers the winning write into one output stage that directly drives the register file's RegWrite/WriteRegister/WriteData.
- Drops writes to $0, supports a hold (stall) and a flush, and keeps a saturating conflict counter for performance debug.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, width of register address.
- CNT_W, 16, width of the conflict counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has a write pending.
- req0_addr  input  ADDR_W  destination register of requester 0.
- req0_data  input  DATA_W  write data of requester 0.
- req0_ready  output  1  requester 0's write is accepted this cycle.
- req1_valid  input  1  requester 1 has a write pending.
- req1_addr  input  ADDR_W  destination register of requester 1.
- req1_data  input  DATA_W  write data of requester 1.
- req1_ready  output  1  requester 1's write is accepted this cycle.
- hold  input  1  freeze acceptance; the output stage still drains.
- flush  input  1  discard the output stage and reset the priority.
- RegWrite  output  1  register file write enable (registered).
- WriteRegister  output  ADDR_W  register file write address (registered).
- WriteData  output  DATA_W  register file write data (registered).
- conflict_cnt  output  CNT_W  count of cycles in which both requesters were valid and one was accepted.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: RegWrite=0, WriteRegister=0, WriteData=0, conflict_cnt=0, rr_last=1 (so req0 wins the first conflict).
- Handshake:
  - A transfer occurs on a posedge where reqN_valid && reqN_ready.
  - A requester holds valid, addr and data stable until ready is seen.
  - ready is combinational from the valids, rr_last, hold and flush. There is no combinational path from ready back to valid.
- Grant:
  - Only one requester valid -> that requester is granted.
  - Both valid -> the requester != rr_last is granted.
  - At most one ready is high per cycle.
  - readyN = grantN && !hold && !flush && !rst.
- rr_last updates to the accepted requester's index on every transfer and is unchanged otherwise.
- Latency: a transfer at posedge N drives RegWrite=1 with the captured addr/data during cycle N+1. The register file commits at posedge N+1. Sustained throughput is one write per cycle.
- Output stage update at each posedge, in priority order:
  1. rst -> reset values.
  2. flush -> RegWrite=0, rr_last=1; addr/data hold.
  3. Transfer -> WriteRegister=addr, WriteData=data, RegWrite=(addr!=0).
  4. Otherwise -> RegWrite=0; addr/data hold.
- Writes to $0: the transfer completes (ready=1) but RegWrite stays 0. The register file must never see a $0 write.
- hold: no acceptance. RegWrite drops to 0 on the next cycle, so the last accepted write is not repeated.
- conflict_cnt:
  - Increments on a posedge with both valids high and a transfer occurring.
  - Saturates at all-ones.
  - Cleared only by rst; flush does not clear it.
- Simultaneous flush and valid: flush wins; nothing is accepted and ready=0.
- Reset mid-operation: a pending write in the output stage is lost (RegWrite=0 the next cycle). Requesters must re-present.

Decomposition:
- Shared package holds the DATA_W/ADDR_W defaults and the constant REG_ZERO = 5'd0.
- One natural sub-module: rr_arbiter2, a two-way round-robin grant with the rr_last register and an update-enable input.
- The output stage and the counter stay in the top.

Test Plan:
- Single writer: req0 valid, addr=5, data=0x1234 for 1 cycle -> req0_ready=1. Next cycle RegWrite=1, WriteRegister=5, WriteData=0x1234. Following cycle RegWrite=0.
- Conflict round-robin: both valid for 4 cycles, req0 addr 1..4, req1 addr 9..12, all re-presented after acceptance -> grant order 0,1,0,1. conflict_cnt=4.
- Write to $0: req1 valid, addr=0, data=0xFFFF -> req1_ready=1, RegWrite stays 0.
- Hold: both valid with hold=1 for 3 cycles -> both ready=0, RegWrite=0. Release hold -> req0 accepted first after reset.
- Flush priority: req0 valid, addr=7, with flush=1 -> req0_ready=0, RegWrite=0 next cycle. With flush=0 on the next cycle -> accepted.
- Back-to-back and saturation: req0 continuous writes, addr 1..31 -> RegWrite high for 31 consecutive cycles. Force the counter to 0xFFFF via a conflict stream -> it stays 0xFFFF.
